reg_file_sb: RTL
================

# reg_file_sb

Parametrised register file with integrated register scoreboard for the pipelined RISC-V core. It supersedes the fixed 32x32, two-read, one-write file. It adds configurable width, depth and read-port count, optional write-to-read bypass, and per-register busy tracking. It sits in decode: read ports feed operand fetch, busy flags drive the hazard/stall logic, and the write/clear port is driven by writeback.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2); AW = $clog2(NREGS)
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports; 0 = no forwarding

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ra  in  [NRD-1:0][AW-1:0]  read addresses
- rd  out  [NRD-1:0][XLEN-1:0]  read data
- rd_busy  out  [NRD-1:0]  1 = register at ra[i] has an outstanding producer
- we  in  1  writeback enable
- wa  in  AW  writeback address
- wd  in  XLEN  writeback data
- iss_valid  in  1  instruction issued with a destination register
- iss_rd  in  AW  destination of issued instruction
- busy_cnt  out  $clog2(NREGS+1)  number of registers currently busy
- sb_full  out  1  busy_cnt == NREGS-1, meaning every writable register is busy

## Operation
- Storage: NREGS × XLEN registers plus NREGS busy bits.
- Register 0 is hardwired:
  - Reads of address 0 return 0 and rd_busy = 0.
  - Writes to 0 are ignored.
  - Issues to 0 are ignored.
  - busy[0] is never set.
- Write: on the clock edge with we=1 and wa≠0, reg[wa] ← wd and busy[wa] ← 0.
- Issue: on the clock edge with iss_valid=1 and iss_rd≠0, busy[iss_rd] ← 1.
- Simultaneous write and issue to the same register:
  - Data is written.
  - busy stays/becomes 1, because issue wins; the new producer supersedes the one retiring.
- Read (combinational, per port i):
  - ra[i]=0 → rd=0, rd_busy=0.
  - If BYPASS=1, we=1 and wa==ra[i]≠0 → rd=wd, rd_busy=0.
  - Otherwise rd=reg[ra[i]] and rd_busy=busy[ra[i]].
  - Same-cycle issue does not affect rd_busy; it becomes visible next cycle.
- With BYPASS=0, a same-cycle write is visible on reads only after the edge, and rd_busy reflects the pre-edge busy bit.
- busy_cnt is registered and updated each edge by the net change:
  - +1 when a set hits a non-busy register.
  - −1 when a clear hits a busy register with no same-register issue.
  - A set and a clear on different registers give net 0.
  - busy_cnt always equals popcount(busy).
- A clear of a non-busy register is a legal no-op. busy_cnt is unchanged.
- An issue to an already-busy register (WAW) is legal. busy stays 1 and busy_cnt is unchanged.

## Timing
- Reset (reset=0) takes effect immediately, independent of clk:
  - All registers become 0 and all busy bits become 0.
  - busy_cnt=0 and sb_full=0.
  - Read outputs follow combinationally, so rd=0 and rd_busy=0 except for bypass.
- Reset deassertion: the first edge with reset=1 performs normal updates.
- Reset asserted mid-operation discards any in-flight write or issue that cycle.
- Write latency: 1 edge to storage. With BYPASS=1 the write is visible on rd in the same cycle.
- Busy set latency: 1 edge. Busy clear latency: 1 edge, or 0 cycles to rd_busy when BYPASS=1.
- Ports are independent. Any read port may alias any other or the write address.
- No handshake and no back-pressure. The issue stage must check rd_busy and sb_full itself.

## Test plan
- Reset/x0: assert reset=0 mid-run after writing reg5=0xDEADBEEF. All rd→0 and busy_cnt→0 asynchronously. Then write wa=0, wd=0x1234; reading ra=0 → 0.
- Write/read, BYPASS=1: we=1, wa=7, wd=0xCAFEF00D with ra[0]=7 → rd[0]=0xCAFEF00D in the same cycle. With BYPASS=0 the same stimulus returns the old value 0 until the edge, then 0xCAFEF00D.
- Scoreboard:
  - Issue iss_rd=3 → next cycle rd_busy=1 for ra=3 and busy_cnt=1.
  - Writeback wa=3 with BYPASS=1 → rd_busy=0 same cycle.
  - After the edge, busy_cnt=0.
- Simultaneous same register: issue iss_rd=9 while writeback wa=9 (busy[9]=1) → reg9 updated, busy[9] remains 1, busy_cnt unchanged.
- Simultaneous different registers: issue 4 and clear busy 6 → busy_cnt unchanged, busy[4]=1, busy[6]=0.
- Full: issue registers 1..31 on successive cycles → busy_cnt=31 and sb_full=1. Re-issuing 31 keeps the count at 31. Writing back 31 → busy_cnt=30 and sb_full=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register file with per-register busy scoreboard for the decode stage.
// Read ports are combinational; writeback clears busy, issue sets it, and issue wins a same-register tie.
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NRD-1:0][AW-1:0]    ra,
    output logic [NRD-1:0][XLEN-1:0]  rd,
    output logic [NRD-1:0]            rd_busy,
    input  logic                      we,
    input  logic [AW-1:0]             wa,
    input  logic [XLEN-1:0]           wd,
    input  logic                      iss_valid,
    input  logic [AW-1:0]             iss_rd,
    output logic [CW-1:0]             busy_cnt,
    output logic                      sb_full
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_busyCnt;

    logic             w_doWrite;
    logic             w_doIssue;
    logic             w_cntInc;
    logic             w_cntDec;
    logic [NREGS-1:0] w_busyNext;
    logic [CW-1:0]    w_cntNext;

    assign w_doWrite = we && (wa != '0);
    assign w_doIssue = iss_valid && (iss_rd != '0);

    // A retiring producer only decrements when no new producer claims the same register.
    assign w_cntInc = w_doIssue && !r_busy[iss_rd];
    assign w_cntDec = w_doWrite && r_busy[wa] && !(w_doIssue && (iss_rd == wa));

    always_comb begin
        w_busyNext = r_busy;
        if (w_doWrite) begin
            w_busyNext[wa] = 1'b0;
        end
        if (w_doIssue) begin
            w_busyNext[iss_rd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_comb begin
        w_cntNext = r_busyCnt;
        if (w_cntInc && !w_cntDec) begin
            w_cntNext = r_busyCnt + CW'(1);
        end else if (w_cntDec && !w_cntInc) begin
            w_cntNext = r_busyCnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_doWrite) begin
            r_regs[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy    <= '0;
            r_busyCnt <= '0;
        end else begin
            r_busy    <= w_busyNext;
            r_busyCnt <= w_cntNext;
        end
    end

    // Same-cycle issue is deliberately invisible here; it shows up after the edge.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd[i]      = '0;
            rd_busy[i] = 1'b0;
            if (ra[i] != '0) begin
                if ((BYPASS != 0) && we && (wa == ra[i])) begin
                    rd[i] = wd;
                end else begin
                    rd[i]      = r_regs[ra[i]];
                    rd_busy[i] = r_busy[ra[i]];
                end
            end
        end
    end

    assign busy_cnt = r_busyCnt;
    assign sb_full  = (r_busyCnt == CW'(NREGS - 1));

endmodule
